// File: rtl/tt_pad_cfg_seq.sv
// Runtime pad-mode controller: modes stream into a shadow bank and commit atomically to the active bank.
// Optional readback port (rd_idx/rd_data) is enabled by defining TT_PAD_CFG_READBACK_EN.
module tt_pad_cfg_seq #(
  parameter int                  N_PADS      = 48,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [4*N_PADS-1:0] RST_CFG     = {N_PADS{4'hA}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_start,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [3:0]          ld_data,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic [4*N_PADS-1:0] pad_mode,
  input  logic [N_PADS-1:0]   core_out,
  input  logic [N_PADS-1:0]   core_oe,
  output logic [N_PADS-1:0]   core_in,
  output logic [N_PADS-1:0]   pad_out,
  output logic [N_PADS-1:0]   pad_oe,
  input  logic [N_PADS-1:0]   pad_in
`ifdef TT_PAD_CFG_READBACK_EN
  ,
  input  logic [5:0]          rd_idx,
  output logic [3:0]          rd_data
`endif
);

  localparam int IDX_W = (N_PADS > 1) ? $clog2(N_PADS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PADS - 1);

  localparam logic [3:0] MODE_NC     = 4'h0;
  localparam logic [3:0] MODE_IN     = 4'hA;
  localparam logic [3:0] MODE_OUT    = 4'h9;
  localparam logic [3:0] MODE_INOUT  = 4'hB;
  localparam logic [3:0] MODE_ANALOG = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT
  } state_t;

  state_t                     state_reg, state_next;
  logic [IDX_W-1:0]           idx_reg, idx_next;
  logic                       cfg_err_reg, cfg_err_next;
  logic [N_PADS-1:0][3:0]     shadow_reg;
  logic [N_PADS-1:0][3:0]     active_reg;
  logic [SYNC_STAGES-1:0][N_PADS-1:0] sync_reg;
  logic                       load_we;
  logic [3:0]                 load_word;
  logic                       commit;
  logic                       word_legal;

  assign word_legal = (ld_data == MODE_NC) || (ld_data == MODE_IN) || (ld_data == MODE_OUT) ||
                      (ld_data == MODE_INOUT) || (ld_data == MODE_ANALOG);

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    cfg_err_next = cfg_err_reg;
    load_we      = 1'b0;
    load_word    = word_legal ? ld_data : MODE_NC;
    commit       = 1'b0;
    ld_ready     = 1'b0;
    cfg_done     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (ld_start) begin
          state_next   = S_LOAD;
          idx_next     = '0;
          cfg_err_next = 1'b0;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        // A restart takes priority over a word presented in the same cycle.
        if (ld_start) begin
          idx_next     = '0;
          cfg_err_next = 1'b0;
        end else if (ld_valid) begin
          load_we = 1'b1;
          if (!word_legal) cfg_err_next = 1'b1;
          if (idx_reg == IDX_LAST) begin
            state_next = S_COMMIT;
            idx_next   = '0;
          end else begin
            idx_next = IDX_W'(idx_reg + 1'b1);
          end
        end
      end
      S_COMMIT: begin
        commit     = 1'b1;
        cfg_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= RST_CFG;
      active_reg <= RST_CFG;
    end else begin
      for (int i = 0; i < N_PADS; i++) begin
        if (load_we && (idx_reg == IDX_W'(i))) shadow_reg[i] <= load_word;
      end
      if (commit) active_reg <= shadow_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= '0;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], pad_in};
  end

  assign cfg_err  = cfg_err_reg;
  assign pad_mode = active_reg;

  // Per-pad gating is purely combinational from the committed mode.
  for (genvar gi = 0; gi < N_PADS; gi++) begin : g_pad
    logic is_out, is_inout, is_in;
    assign is_out      = (active_reg[gi] == MODE_OUT);
    assign is_inout    = (active_reg[gi] == MODE_INOUT);
    assign is_in       = (active_reg[gi] == MODE_IN);
    assign pad_oe[gi]  = is_out | (is_inout & core_oe[gi]);
    assign pad_out[gi] = (is_out | is_inout) & core_out[gi];
    assign core_in[gi] = (is_in | is_inout) & sync_reg[SYNC_STAGES-1][gi];
  end

`ifdef TT_PAD_CFG_READBACK_EN
  always_comb begin
    rd_data = 4'h0;
    for (int i = 0; i < N_PADS; i++) begin
      if (rd_idx == 6'(i)) rd_data = active_reg[i];
    end
  end
`endif

endmodule

// File: tb/tb_tt_pad_cfg_seq.sv
// Randomised scoreboard bench for tt_pad_cfg_seq (N_PADS=4): commits are checked by a monitor
// against expectations queued by the load driver; gating and input sync are checked directly.
module tb_tt_pad_cfg_seq;
  localparam int N  = 4;
  localparam int SS = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ld_start = 1'b0;
  logic           ld_valid = 1'b0;
  logic [3:0]     ld_data = 4'h0;
  logic           ld_ready, cfg_done, cfg_err;
  logic [4*N-1:0] pad_mode;
  logic [N-1:0]   core_out = '0, core_oe = '0, pad_in = '0;
  logic [N-1:0]   core_in, pad_out, pad_oe;
`ifdef TT_PAD_CFG_READBACK_EN
  logic [5:0]     rd_idx = 6'd0;
  logic [3:0]     rd_data;
`endif

  tt_pad_cfg_seq #(.N_PADS(N), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .pad_mode(pad_mode),
    .core_out(core_out), .core_oe(core_oe), .core_in(core_in),
    .pad_out(pad_out), .pad_oe(pad_oe), .pad_in(pad_in)
`ifdef TT_PAD_CFG_READBACK_EN
    , .rd_idx(rd_idx), .rd_data(rd_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain per-pad arrays of mode codes.
  logic [3:0] ref_active [N];
  logic [3:0] ref_shadow [N];
  bit         ref_err;
  logic [3:0] wbuf [N];

  typedef struct packed {
    logic [4*N-1:0] old_mode;
    logic [4*N-1:0] new_mode;
    logic           err;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [3:0] w);
    return (w == 4'h0) || (w == 4'hA) || (w == 4'h9) || (w == 4'hB) || (w == 4'hC);
  endfunction

  function automatic logic [4*N-1:0] pack_active();
    logic [4*N-1:0] r;
    for (int i = 0; i < N; i++) r[4*i +: 4] = ref_active[i];
    return r;
  endfunction

  function automatic logic [4*N-1:0] pack_shadow();
    logic [4*N-1:0] r;
    for (int i = 0; i < N; i++) r[4*i +: 4] = ref_shadow[i];
    return r;
  endfunction

  function automatic logic [N-1:0] in_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (ref_active[i] == 4'hA) || (ref_active[i] == 4'hB);
    return m;
  endfunction

  function automatic logic [3:0] rand_word();
    logic [3:0] legal_set [5];
    legal_set[0] = 4'h0; legal_set[1] = 4'hA; legal_set[2] = 4'h9;
    legal_set[3] = 4'hB; legal_set[4] = 4'hC;
    if ($urandom_range(0, 9) < 7) return legal_set[$urandom_range(0, 4)];
    return 4'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ref_active[i] = 4'hA;
      ref_shadow[i] = 4'hA;
    end
    ref_err = 1'b0;
  endtask

  // ld_start optionally accompanied by a valid word, which must be discarded.
  task automatic start_load(input bit with_word);
    ld_start = 1'b1;
    if (with_word) begin
      ld_valid = 1'b1;
      ld_data  = 4'h9;
    end
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ref_err  = 1'b0;
    $display("ld_start with_word=%0d", with_word);
    check("cfg_err_clear_on_start", cfg_err, 1'b0);
  endtask

  task automatic send_word(input logic [3:0] w, input int i);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) tick();
    check("ld_ready_in_load", ld_ready, 1'b1);
    ld_valid = 1'b1;
    ld_data  = w;
    tick();
    ld_valid = 1'b0;
    ref_shadow[i] = legal(w) ? w : 4'h0;
    if (!legal(w)) ref_err = 1'b1;
    $display("word idx=%0d data=%0h gap=%0d", i, w, gap);
  endtask

  task automatic full_load(input bit start_with_word, input bit start_in_commit);
    exp_t e;
    start_load(start_with_word);
    for (int i = 0; i < N; i++) send_word(wbuf[i], i);
    e.old_mode = pack_active();
    e.new_mode = pack_shadow();
    e.err      = ref_err;
    sb_q.push_back(e);
    for (int i = 0; i < N; i++) ref_active[i] = ref_shadow[i];
    if (start_in_commit) begin
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      check("ld_start_ignored_in_commit", ld_ready, 1'b0);
      check("cfg_err_kept_after_commit", cfg_err, ref_err);
    end else begin
      tick();
    end
    tick();
    tick();
  endtask

  task automatic check_gating();
    logic [N-1:0] exp_oe, exp_out;
    core_out = N'($urandom);
    core_oe  = N'($urandom);
    #1;
    for (int i = 0; i < N; i++) begin
      case (ref_active[i])
        4'h9:    begin exp_oe[i] = 1'b1;       exp_out[i] = core_out[i]; end
        4'hB:    begin exp_oe[i] = core_oe[i]; exp_out[i] = core_out[i]; end
        default: begin exp_oe[i] = 1'b0;       exp_out[i] = 1'b0;        end
      endcase
    end
    $display("gating mode=%0h core_out=%0h core_oe=%0h", pack_active(), core_out, core_oe);
    check("pad_mode", pad_mode, pack_active());
    check("pad_oe", pad_oe, exp_oe);
    check("pad_out", pad_out, exp_out);
  endtask

  task automatic check_input();
    logic [N-1:0] old_in;
    pad_in = N'($urandom);
    repeat (SS + 1) tick();
    old_in = pad_in;
    pad_in = N'($urandom);
    tick();
    check("core_in_before_latency", core_in, old_in & in_mask());
    tick();
    check("core_in_after_latency", core_in, pad_in & in_mask());
    $display("input old=%0h new=%0h mask=%0h", old_in, pad_in, in_mask());
  endtask

  // Monitor: every cfg_done pulse consumes one queued commit expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && cfg_done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cfg_done_unexpected: got cfg_done=1 expected no commit");
        end else begin
          e = sb_q.pop_front();
          $display("commit old=%0h new=%0h err=%0d", e.old_mode, e.new_mode, e.err);
          check("mode_held_during_commit", pad_mode, e.old_mode);
          check("cfg_err_at_commit", cfg_err, e.err);
          @(negedge clk);
          check("mode_after_commit", pad_mode, e.new_mode);
          check("cfg_done_one_cycle", cfg_done, 1'b0);
        end
      end
    end
  end

  initial begin
    int budget;
    model_reset();
    repeat (3) tick();
    check("rst_pad_mode", pad_mode, pack_active());
    check("rst_ld_ready", ld_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_pad_mode", pad_mode, {N{4'hA}});
    check("idle_pad_oe", pad_oe, '0);
    check("idle_ld_ready", ld_ready, 1'b0);
    check("idle_cfg_done", cfg_done, 1'b0);
    check("idle_cfg_err", cfg_err, 1'b0);
    check_input();

    // Directed load 9,B,A,0.
    wbuf[0] = 4'h9; wbuf[1] = 4'hB; wbuf[2] = 4'hA; wbuf[3] = 4'h0;
    full_load(1'b0, 1'b0);
    core_oe = 4'b0010;
    #1;
    check("dir_pad_oe_oe1", pad_oe, 4'b0011);
    core_oe = 4'b1101;
    #1;
    check("dir_pad_oe_oe0", pad_oe, 4'b0001);
`ifdef TT_PAD_CFG_READBACK_EN
    rd_idx = 6'd0; #1; check("rd_idx0", rd_data, 4'h9);
    rd_idx = 6'd1; #1; check("rd_idx1", rd_data, 4'hB);
    rd_idx = 6'd7; #1; check("rd_idx7", rd_data, 4'h0);
`endif
    check_gating();
    check_input();

    // Partial load then restart (with a same-cycle word) then all IN.
    start_load(1'b0);
    for (int i = 0; i < 3; i++) send_word(4'h9, i);
    check("mode_before_commit", pad_mode, pack_active());
    for (int i = 0; i < N; i++) wbuf[i] = 4'hA;
    full_load(1'b1, 1'b0);
    check_gating();

    // Illegal word at index 2; ld_start during COMMIT must be ignored.
    wbuf[0] = 4'h9; wbuf[1] = 4'h9; wbuf[2] = 4'h5; wbuf[3] = 4'hB;
    full_load(1'b0, 1'b1);
    repeat (3) tick();
    check("cfg_err_sticky", cfg_err, 1'b1);
    check_gating();

    // Reset in the middle of a load.
    start_load(1'b0);
    send_word(4'h9, 0);
    send_word(4'hB, 1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    $display("async reset mid-load");
    check("midrst_pad_mode", pad_mode, pack_active());
    check("midrst_ld_ready", ld_ready, 1'b0);
    check("midrst_cfg_err", cfg_err, 1'b0);
    check("midrst_core_in", core_in, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("postrst_ld_ready", ld_ready, 1'b0);

    // Randomised loads with optional restarts.
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(1, N - 1);
        start_load(1'b0);
        for (int i = 0; i < k; i++) send_word(rand_word(), i);
      end
      for (int i = 0; i < N; i++) wbuf[i] = rand_word();
      full_load(1'($urandom), 1'($urandom));
      check_gating();
      if (t % 3 == 0) check_input();
    end

    budget = 0;
    while (sb_q.size() != 0 && budget < 20) begin
      tick();
      budget++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
